c_readout: RTL
==============

# c_readout

Drains the systolic array's result buffer (C buffer: `ar_size` rows of `ar_size` packed signed 32-bit accumulators) and streams it to the CFU response path. It is the reader that pairs with the array's C-buffer writer. It starts after the array deasserts `busy`, reads rows by index, and requantizes each accumulator to int8 (multiply, rounding right shift, offset, clamp). Each row goes out as one 32-bit word over a valid/ready handshake.

## Interface
- `C_depth`, 2: C buffer index width
- `ar_size`, 4: rows per drain; lanes per row (fixed at 4 by the 128/32-bit widths)
- `clk`  in  1: clock
- `rst`  in  1: asynchronous, active-high reset
- `start`  in  1: begin a drain; sampled only in IDLE
- `multiplier`  in  32: signed requant multiplier; captured at start
- `shift`  in  6: right-shift amount 0..63; captured at start
- `out_offset`  in  32: signed output zero point; captured at start
- `act_min`, `act_max`  in  8 each: signed clamp bounds (act_min ≤ act_max); captured at start
- `C_index`  out  C_depth: C buffer read row
- `C_data_in`  in  128: row data; lane i = bits [32i+31:32i], valid one cycle after `C_index` is presented
- `out_data`  out  32: packed int8 results; lane i = bits [8i+7:8i]
- `out_valid`  out  1: `out_data` valid
- `out_ready`  in  1: consumer accepts
- `busy`  out  1: high in every non-IDLE state
- `done`  out  1: one-cycle pulse after the last row is accepted

## Operation
- States:
  - IDLE: `start` → ADDR with row=0 and parameters latched.
  - ADDR: `C_index`=row → CAPT.
  - CAPT: latch `C_data_in` into a 128-bit register → MUL.
  - MUL: register four signed 64-bit products acc×multiplier → FIN.
  - FIN: compute, register `out_data`, set `out_valid` → OUT.
  - OUT: hold until `out_valid && out_ready`.
    - If row == ar_size-1 → IDLE with `done` pulse.
    - Otherwise row+1 → ADDR.
- Per lane:
  - p = acc × multiplier, 64-bit signed.
  - r = p when shift=0; otherwise (p + 2^(shift-1)) >>> shift, arithmetic, computed at 64 bits.
  - s = r + sign-extended out_offset, 64-bit.
  - Clamp s to [act_min, act_max]; emit low 8 bits.
- `start` while not IDLE: ignored. Input parameter changes mid-drain: no effect.
- `C_index` is 0 outside ADDR/CAPT and holds the row value through CAPT.
- Reset values: `C_index`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, row=0, all internal registers 0.
- Reset mid-drain: immediate return to IDLE. The partial row is discarded and no `done` is issued. The next `start` begins again at row 0.

## Timing
- `start` sampled high at edge 0:
  - ADDR during cycle 1, CAPT cycle 2, MUL cycle 3, FIN cycle 4.
  - `out_valid` high from cycle 5.
- Minimum 5 cycles per row with `out_ready` tied high. A full 4-row drain takes 20 cycles from start to the last handshake; `done` is high in the following cycle.
- `out_data` and `out_valid` are stable while `out_valid && !out_ready`. `out_valid` never drops without a handshake, except on reset.
- `out_valid` falls on the edge that completes the handshake. It is low for at least 4 cycles between rows.
- `busy` rises on the edge after `start` is sampled. It falls together with the `done` pulse.

## Test plan
- Identity (mult=1, shift=0, offset=0, min=-128, max=127), row0={5,-3,127,-128}, other rows 0 → word0=0x807FFD05, words1-3=0x00000000, `done` one cycle after fourth handshake, `busy` low with it.
- Rounding (mult=1, shift=1), lanes {7,-7,-5,1} → {4,-3,-2,1} → 0x01FEFD04. Also mult=0x40000000, shift=31, acc=3 → 2 (0x02).
- Clamp (mult=1, shift=0, offset=10, min=-20, max=100), lanes {1000,-1000,0,90} → {100,-20,10,100} → 0x640AEC64.
- Backpressure: `out_ready` low 5 cycles at row1 → `out_data` and `out_valid` constant, `C_index` stays 0 and no row2 read occurs, exactly 4 handshakes, one `done`.
- `start` pulsed again mid-drain, and `multiplier` changed mid-drain → output words identical to an undisturbed run.
- `rst` asserted while row1 is in OUT → `out_valid`, `busy`, `C_index` go to 0 immediately and there is no `done`. A new `start` then yields row0 first.

Source files
------------

// File: rtl/c_readout_if.sv
// Output stream of the C-buffer reader: one packed int8x4 word per row.
// Handshake: the producer raises out_valid with out_data; both stay stable
// until a cycle where out_valid && out_ready, which transfers the word.
// out_valid never drops without a transfer (reset excepted).
interface c_readout_if;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/c_readout.sv
// Drains the systolic array's C buffer row by row, requantizes each signed
// 32-bit accumulator to int8 (multiply, rounding shift, offset, clamp) and
// streams one packed 32-bit word per row over the c_readout_if handshake.
module c_readout #(
  parameter int C_depth = 2,
  parameter int ar_size = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        multiplier,
  input  logic [5:0]         shift,
  input  logic [31:0]        out_offset,
  input  logic [7:0]         act_min,
  input  logic [7:0]         act_max,
  output logic [C_depth-1:0] C_index,
  input  logic [127:0]       C_data_in,
  c_readout_if.master        ro,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    CAPT = 3'd2,
    MUL  = 3'd3,
    FIN  = 3'd4,
    OUT  = 3'd5
  } state_t;

  localparam logic [C_depth-1:0] LAST_ROW = C_depth'(ar_size - 1);

  state_t              state;
  logic [C_depth-1:0]  row_q;
  logic [31:0]         mult_q;
  logic [5:0]          shift_q;
  logic [31:0]         offset_q;
  logic [7:0]          min_q;
  logic [7:0]          max_q;
  logic [127:0]        c_row_q;
  logic signed [63:0]  prod_q [4];
  logic [31:0]         out_data_q;
  logic                out_valid_q;
  logic [31:0]         fin_word;

  assign ro.out_data  = out_data_q;
  assign ro.out_valid = out_valid_q;
  assign state_dbg    = state;

  // Full-width signed product of one accumulator lane and the multiplier.
  function automatic logic signed [63:0] mul64(input logic [31:0] a,
                                               input logic [31:0] b);
    logic signed [63:0] a64;
    logic signed [63:0] b64;
    a64 = {{32{a[31]}}, a};
    b64 = {{32{b[31]}}, b};
    return a64 * b64;
  endfunction

  // Rounding arithmetic shift (half rounds toward +inf), offset, clamp.
  function automatic logic [7:0] requant(input logic signed [63:0] p,
                                         input logic [5:0]         sh,
                                         input logic [31:0]        off,
                                         input logic [7:0]         lo,
                                         input logic [7:0]         hi);
    logic signed [63:0] r;
    logic signed [63:0] s;
    logic signed [63:0] off64;
    logic signed [63:0] lo64;
    logic signed [63:0] hi64;
    off64 = {{32{off[31]}}, off};
    lo64  = {{56{lo[7]}}, lo};
    hi64  = {{56{hi[7]}}, hi};
    if (sh == 6'd0) r = p;
    else            r = (p + (64'sd1 <<< (sh - 6'd1))) >>> sh;
    s = r + off64;
    if (s < lo64)      return lo;
    else if (s > hi64) return hi;
    else               return s[7:0];
  endfunction

  // Final stage of the lane pipeline: requantize the registered products.
  always_comb begin
    fin_word = '0;
    for (int i = 0; i < 4; i++) begin
      fin_word[8*i +: 8] = requant(prod_q[i], shift_q, offset_q, min_q, max_q);
    end
  end

  // Drain sequencer: address, capture, multiply, finish, then hold the
  // word until it is accepted; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      row_q       <= '0;
      mult_q      <= '0;
      shift_q     <= '0;
      offset_q    <= '0;
      min_q       <= '0;
      max_q       <= '0;
      c_row_q     <= '0;
      for (int i = 0; i < 4; i++) prod_q[i] <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      C_index     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ADDR;
            row_q    <= '0;
            C_index  <= '0;
            busy     <= 1'b1;
            mult_q   <= multiplier;
            shift_q  <= shift;
            offset_q <= out_offset;
            min_q    <= act_min;
            max_q    <= act_max;
          end
        end
        ADDR: begin
          // C_index already carries the row; the buffer answers next cycle.
          state <= CAPT;
        end
        CAPT: begin
          c_row_q <= C_data_in;
          C_index <= '0;
          state   <= MUL;
        end
        MUL: begin
          for (int i = 0; i < 4; i++) begin
            prod_q[i] <= mul64(c_row_q[32*i +: 32], mult_q);
          end
          state <= FIN;
        end
        FIN: begin
          out_data_q  <= fin_word;
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (ro.out_ready) begin
            out_valid_q <= 1'b0;
            if (row_q == LAST_ROW) begin
              state <= IDLE;
              row_q <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              row_q   <= row_q + C_depth'(1);
              C_index <= row_q + C_depth'(1);
              state   <= ADDR;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
